inv_shift_rows_stream: RTL
==========================

INV_SHIFT_ROWS_STREAM -- requirements
Module: inv_shift_rows_stream

Interface
REQ-001 Parameter: FORWARD, default 0, 0 = InvShiftRows (decrypt path), 1 = ShiftRows (loopback/test path).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  8  state byte, column-major order: byte k is row k%4, column k/4; byte 0 is the MSB byte of the 128-bit state.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 out_data  output  8  permuted state byte, same column-major order.
REQ-008 out_valid  output  1  out_data valid this cycle.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_last  output  1  high with out_valid on byte 15 of each block.

Function
REQ-011 A byte transfers on any rising edge where valid and ready are both high; no other byte is consumed or produced.
REQ-012 Inverse mapping (FORWARD=0): output byte 4c+r equals input byte 4*((c-r) mod 4)+r, for r,c in 0..3.
REQ-013 Forward mapping (FORWARD=1): output byte 4c+r equals input byte 4*((c+r) mod 4)+r.
REQ-014 Storage: two 16-byte banks (ping-pong), each with a full flag; 4-bit write index, 4-bit read index, 1-bit write-bank select, 1-bit read-bank select.
REQ-015 in_ready is high exactly when the current write bank is not full; it does not depend on in_valid.
REQ-016 Accepted input bytes are written in arrival order at the write index; the write index increments by 1 per transfer and wraps 15 -> 0.
REQ-017 On the transfer at write index 15, the write bank becomes full and the write-bank select toggles.
REQ-018 out_valid is high exactly when the current read bank is full; out_data is the stored byte at the read index's mapped source address, per REQ-012/013.
REQ-019 The read index increments by 1 per output transfer and wraps 15 -> 0.
REQ-020 On the output transfer at read index 15, the read bank's full flag clears and the read-bank select toggles.
REQ-021 out_data, out_last and out_valid remain stable while out_valid is high and out_ready is low.
REQ-022 Latency: first out_valid of a block occurs in the cycle after that block's 16th input transfer.
REQ-023 Throughput: with out_ready held high and input continuous, one byte per cycle is sustained in both directions with no bubbles after the first block.
REQ-024 Simultaneous events: a write completing bank A and a read completing bank B on the same edge both take effect; the two banks' full flags are updated independently.
REQ-025 Both banks full: in_ready low until the read side frees a bank; no input byte is lost or overwritten.
REQ-026 Both banks empty: out_valid low; out_data value is don't-care.
REQ-027 in_data, out_ready are ignored when the corresponding handshake does not transfer.

Reset
REQ-028 While rst_n is low at a rising edge: both full flags clear; write index, read index and both bank selects are zero.
REQ-029 Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_data=8'h00.
REQ-030 Reset mid-block discards any partially written or partially read block; bank contents need no clearing.
REQ-031 First input transfer allowed on the first edge after rst_n returns high.

Verification
REQ-032 FORWARD=0; bytes 00..0f streamed, out_ready=1 -> output 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03, out_last on 03, first out_valid the cycle after byte 0f accepted.
REQ-033 FORWARD=0; input d4bf5d30e0b452aeb84111f11e2798e5 -> output d42711aee0bf98f1b8b45de51e415230.
REQ-034 FORWARD=1; bytes 00..0f -> output 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
REQ-035 out_ready=0, continuous input of 3 blocks -> in_ready falls after byte 31 is accepted; out_data held at first byte; on out_ready=1, blocks 1 and 2 emerge intact and in order.
REQ-036 Reset pulse after 7 input bytes -> in_ready=1, out_valid=0; next 16 bytes form a complete block with correct output.
REQ-037 Back-to-back 4 blocks, random in_valid/out_ready gaps -> output matches a reference model byte-for-byte; no drop, duplicate or reorder.

Source files
------------

// File: rtl/inv_shift_rows_stream.sv
// inv_shift_rows_stream
//
// Byte-serial AES (Inv)ShiftRows. A 128-bit state arrives one byte per
// transfer in column-major order (byte k = row k%4, column k/4, byte 0 first).
// Once all 16 bytes of a block are stored, the permuted block is streamed out
// in the same column-major order. Two 16-byte banks are used ping-pong so that
// one block can be filled while the previous one drains.
//
// Parameters
//   FORWARD    0: InvShiftRows (decrypt path), 1: ShiftRows (loopback/test)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    input state byte
//   in_valid   in_data valid
//   in_ready   a byte can be accepted (current write bank not full)
//   out_data   permuted state byte (00 while no block is available)
//   out_valid  out_data valid (current read bank full)
//   out_ready  downstream accepts out_data
//   out_last   with out_valid on byte 15 of each block

module inv_shift_rows_stream #(
    parameter bit FORWARD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    logic [7:0] bank [2][16];
    logic [1:0] full;
    logic [3:0] wr_idx;
    logic [3:0] rd_idx;
    logic       wr_sel;
    logic       rd_sel;

    logic       in_fire;
    logic       out_fire;
    logic [1:0] rd_row;
    logic [1:0] rd_col;
    logic [1:0] src_col;
    logic [3:0] src_addr;

    assign in_ready  = ~full[wr_sel];
    assign out_valid = full[rd_sel];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Output byte 4c+r comes from column (c-r) mod 4 (inverse) or (c+r) mod 4
    // (forward) of the same row; 2-bit arithmetic gives the mod-4 wrap.
    assign rd_row   = rd_idx[1:0];
    assign rd_col   = rd_idx[3:2];
    assign src_col  = FORWARD ? (rd_col + rd_row) : (rd_col - rd_row);
    assign src_addr = {src_col, rd_row};

    assign out_data = out_valid ? bank[rd_sel][src_addr] : 8'h00;
    assign out_last = out_valid & (rd_idx == 4'd15);

    // Bank contents carry no reset; a bank is only read once its full flag
    // is set, which requires 16 fresh writes after reset.
    always_ff @(posedge clk) begin
        if (rst_n && in_fire) begin
            bank[wr_sel][wr_idx] <= in_data;
        end
    end

    // Write and read always target different banks when both fire (the write
    // bank is not full, the read bank is), so the two full-flag updates never
    // collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full   <= 2'b00;
            wr_idx <= 4'd0;
            rd_idx <= 4'd0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_idx <= wr_idx + 4'd1;
                if (wr_idx == 4'd15) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                end
            end
            if (out_fire) begin
                rd_idx <= rd_idx + 4'd1;
                if (rd_idx == 4'd15) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end
            end
        end
    end

endmodule
